// File: rtl/obi_tmr_voter.sv
// TMR voter on the data OBI path: majority-votes three hart requests onto one bus port,
// broadcasts the single response back and records which harts disagreed.
module obi_tmr_voter #(
   parameter int unsigned SKEW_MAX = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [2:0]           core_req_i,
   input  logic [2:0]           core_we_i,
   input  logic [2:0][3:0]      core_be_i,
   input  logic [2:0][31:0]     core_addr_i,
   input  logic [2:0][31:0]     core_wdata_i,
   output logic [2:0]           core_gnt_o,
   output logic [2:0]           core_rvalid_o,
   output logic [2:0][31:0]     core_rdata_o,
   output logic                 bus_req_o,
   output logic                 bus_we_o,
   output logic [3:0]           bus_be_o,
   output logic [31:0]          bus_addr_o,
   output logic [31:0]          bus_wdata_o,
   input  logic                 bus_gnt_i,
   input  logic                 bus_rvalid_i,
   input  logic [31:0]          bus_rdata_i,
   input  logic                 clear_i,
   output logic                 error_o,
   output logic [2:0]           faulty_hart_o,
   output logic [CNT_W-1:0]     mismatch_cnt_o
);

   localparam int unsigned VoteW = 69;
   localparam int unsigned SkewW = $clog2(SKEW_MAX + 1);

   typedef enum logic [2:0] {StIdle, StReq, StResp, StAbort, StAbortR} state_e;

   state_e                state_q, state_d;
   logic [SkewW-1:0]      skew_q, skew_d, skew_inc;
   logic [VoteW-1:0]      vote_q, vote_d, voted;
   logic [2:0]            mask_q, mask_d;
   logic [2:0]            faulty_q, faulty_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0][VoteW-1:0] vec;
   logic                  agree01, agree02, agree12, majority;
   logic [2:0]            flag;
   logic                  detect;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         vec[k] = {core_we_i[k], core_be_i[k], core_addr_i[k], core_wdata_i[k]};
      end
   end

   assign agree01  = core_req_i[0] & core_req_i[1] & (vec[0] == vec[1]);
   assign agree02  = core_req_i[0] & core_req_i[2] & (vec[0] == vec[2]);
   assign agree12  = core_req_i[1] & core_req_i[2] & (vec[1] == vec[2]);
   assign majority = agree01 | agree02 | agree12;
   assign voted    = (agree01 | agree02) ? vec[0] : vec[1];
   assign skew_inc = skew_q + SkewW'(1);

   always_comb begin
      state_d       = state_q;
      skew_d        = skew_q;
      vote_d        = vote_q;
      mask_d        = mask_q;
      core_gnt_o    = '0;
      core_rvalid_o = '0;
      core_rdata_o  = '0;
      bus_req_o     = 1'b0;
      flag          = '0;
      detect        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (majority) begin
               vote_d  = voted;
               skew_d  = '0;
               state_d = StReq;
            end else if (|core_req_i) begin
               if (skew_inc == SkewW'(SKEW_MAX)) begin
                  mask_d  = core_req_i;
                  skew_d  = '0;
                  state_d = StAbort;
               end else begin
                  skew_d = skew_inc;
               end
            end else begin
               skew_d = '0;
            end
         end
         StReq: begin
            bus_req_o = 1'b1;
            if (bus_gnt_i) begin
               core_gnt_o = 3'b111;
               // Harts that dropped out or diverged since the vote are flagged at grant
               for (int k = 0; k < 3; k++) begin
                  flag[k] = !core_req_i[k] || (vec[k] != vote_q);
               end
               detect  = |flag;
               state_d = StResp;
            end
         end
         StResp: begin
            if (bus_rvalid_i) begin
               core_rvalid_o = 3'b111;
               core_rdata_o  = {3{bus_rdata_i}};
               state_d       = StIdle;
            end
         end
         StAbort: begin
            core_gnt_o = mask_q;
            flag       = mask_q;
            detect     = 1'b1;
            state_d    = StAbortR;
         end
         StAbortR: begin
            core_rvalid_o = mask_q;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Clear has priority over a same-cycle detection; error_o still pulses
   always_comb begin
      faulty_d = faulty_q | flag;
      cnt_d    = cnt_q;
      if (detect && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (clear_i) begin
         faulty_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         skew_q   <= '0;
         vote_q   <= '0;
         mask_q   <= '0;
         faulty_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         skew_q   <= skew_d;
         vote_q   <= vote_d;
         mask_q   <= mask_d;
         faulty_q <= faulty_d;
         cnt_q    <= cnt_d;
      end
   end

   assign {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} = vote_q;
   assign error_o        = detect;
   assign faulty_hart_o  = faulty_q;
   assign mismatch_cnt_o = cnt_q;

endmodule

// File: tb/tb_obi_tmr_voter.sv
// Randomized bench for obi_tmr_voter against a transaction-level majority model.
module tb_obi_tmr_voter;

   localparam int unsigned SKEW_MAX = 4;
   localparam int unsigned CNT_W    = 8;
   localparam int          CntMax   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0]        core_req, core_we;
   logic [2:0][3:0]   core_be;
   logic [2:0][31:0]  core_addr, core_wdata;
   logic [2:0]        core_gnt, core_rvalid;
   logic [2:0][31:0]  core_rdata;
   logic              bus_req, bus_we;
   logic [3:0]        bus_be;
   logic [31:0]       bus_addr, bus_wdata;
   logic              bus_gnt, bus_rvalid;
   logic [31:0]       bus_rdata;
   logic              clear, error;
   logic [2:0]        faulty;
   logic [CNT_W-1:0]  cnt;

   int                n_tests = 0;
   int                n_fail  = 0;
   logic [2:0]        exp_faulty = '0;
   int                exp_cnt    = 0;

   obi_tmr_voter #(.SKEW_MAX(SKEW_MAX), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
      .core_addr_i(core_addr), .core_wdata_i(core_wdata),
      .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
      .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_be_o(bus_be),
      .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
      .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
      .clear_i(clear), .error_o(error), .faulty_hart_o(faulty), .mismatch_cnt_o(cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [68:0] rand_vec();
      return {1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom};
   endfunction

   task automatic drive_hart(input int k, input logic [68:0] v);
      core_req[k] = 1'b1;
      {core_we[k], core_be[k], core_addr[k], core_wdata[k]} = v;
   endtask

   task automatic drop_harts();
      core_req = '0; core_we = '0; core_be = '0; core_addr = '0; core_wdata = '0;
   endtask

   task automatic note_event(input logic [2:0] flags);
      exp_faulty = exp_faulty | flags;
      if (exp_cnt < CntMax) exp_cnt++;
   endtask

   // Harts 1 and 2 request at cycle 0; hart 0 joins at cycle start0.
   task automatic do_txn(input logic [68:0] v0, input logic [68:0] v1, input logic [68:0] v2,
                         input int start0, input int gnt_dly, input logic [31:0] rd);
      logic [68:0] v [3];
      logic [68:0] voted;
      logic [2:0]  flags;
      int          gnt_cyc, agree;
      bit          found;
      v = '{v0, v1, v2};
      gnt_cyc = 1 + gnt_dly;
      found = 0;
      voted = '0;
      // Majority: the value shared by at least two harts requesting at cycle 0
      for (int k = 0; k < 3; k++) begin
         agree = 0;
         for (int j = 0; j < 3; j++)
            if ((j != 0 || start0 == 0) && v[j] == v[k]) agree++;
         if (!found && (k != 0 || start0 == 0) && agree >= 2) begin
            voted = v[k];
            found = 1;
         end
      end
      for (int k = 0; k < 3; k++)
         flags[k] = ((k == 0) && (start0 > gnt_cyc)) || (v[k] != voted);

      @(posedge clk); #1;
      if (start0 == 0) drive_hart(0, v[0]);
      drive_hart(1, v[1]);
      drive_hart(2, v[2]);
      @(negedge clk);
      check("idle_bus_req", bus_req, 1'b0);
      check("idle_core_gnt", core_gnt, 3'b000);
      for (int c = 1; c <= gnt_cyc; c++) begin
         @(posedge clk); #1;
         if (start0 == c) drive_hart(0, v[0]);
         bus_gnt = (c == gnt_cyc);
         @(negedge clk);
         check("req_bus_req", bus_req, 1'b1);
         check("req_bus_fields", {bus_we, bus_be, bus_addr, bus_wdata}, voted);
         check("req_core_gnt", core_gnt, (c == gnt_cyc) ? 3'b111 : 3'b000);
         check("req_error", error, (c == gnt_cyc) ? |flags : 1'b0);
         check("req_rdata_zero", core_rdata, '0);
      end
      @(posedge clk); #1;
      drop_harts();
      bus_gnt = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata = rd;
      @(negedge clk);
      check("resp_bus_req", bus_req, 1'b0);
      check("resp_rvalid", core_rvalid, 3'b111);
      check("resp_rdata", core_rdata, {rd, rd, rd});
      if (|flags) note_event(flags);
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      bus_rdata = '0;
      @(negedge clk);
      check("post_rvalid", core_rvalid, 3'b000);
      check("post_faulty", faulty, exp_faulty);
      check("post_cnt", cnt, exp_cnt[CNT_W-1:0]);
   endtask

   // Harts in m request with pairwise-different addresses, so no majority forms.
   task automatic do_abort(input logic [2:0] m, input bit clr);
      logic [68:0] base, v;
      base = rand_vec();
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         if (m[k]) begin
            v = base;
            v[33:32] = 2'(k);
            drive_hart(k, v);
         end
      end
      for (int c = 0; c < SKEW_MAX; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         @(negedge clk);
         check("skew_bus_req", bus_req, 1'b0);
         check("skew_core_gnt", core_gnt, 3'b000);
         check("skew_error", error, 1'b0);
      end
      @(posedge clk); #1;
      clear = clr;
      @(negedge clk);
      check("abort_gnt", core_gnt, m);
      check("abort_error", error, 1'b1);
      check("abort_bus_req", bus_req, 1'b0);
      @(posedge clk); #1;
      drop_harts();
      clear = 1'b0;
      @(negedge clk);
      check("abort_rvalid", core_rvalid, m);
      check("abort_rdata", core_rdata, '0);
      if (clr) begin
         exp_faulty = '0;
         exp_cnt = 0;
      end else begin
         note_event(m);
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_post_rvalid", core_rvalid, 3'b000);
      check("abort_faulty", faulty, exp_faulty);
      check("abort_cnt", cnt, exp_cnt[CNT_W-1:0]);
   endtask

   initial begin
      logic [68:0] a, b;
      int          mode, bitpos;
      rst_n = 1'b0;
      drop_harts();
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; clear = 1'b0;
      #3;
      check("rst_outs", {bus_req, core_gnt, core_rvalid, error, faulty, cnt}, '0);
      check("rst_rdata", core_rdata, '0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Identical reads
      a = {1'b0, 4'hF, 32'h0001_0000, 32'h0};
      do_txn(a, a, a, 0, 0, 32'hDEAD_BEEF);
      // Hart 2 writes a different value
      a = {1'b1, 4'hF, 32'h0000_2000, 32'h0};
      b = {1'b1, 4'hF, 32'h0000_2000, 32'h1};
      do_txn(a, a, b, 0, 0, 32'h0);
      // Long grant stall, then reset while a response is outstanding
      a = rand_vec();
      do_txn(a, a, a, 0, 10, $urandom);
      @(posedge clk); #1;
      drive_hart(0, a); drive_hart(1, a); drive_hart(2, a);
      @(posedge clk); #1;
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      drop_harts();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {bus_req, core_gnt, core_rvalid, error, faulty, cnt}, '0);
      check("mid_rst_rdata", core_rdata, '0);
      exp_faulty = '0;
      exp_cnt = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus_rvalid = 1'b1;
      bus_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      check("stale_rvalid", core_rvalid, 3'b000);
      check("stale_bus_req", bus_req, 1'b0);
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      bus_rdata = '0;
      a = rand_vec();
      do_txn(a, a, a, 0, 1, $urandom);

      // Lone requester aborts
      do_abort(3'b010, 1'b0);
      // Hart 0 late but caught up before grant; then too late for grant
      a = rand_vec();
      do_txn(a, a, a, 2, 3, $urandom);
      do_txn(a, a, a, 5, 1, $urandom);
      // All three disagree; then abort with clear in the same cycle
      do_abort(3'b111, 1'b0);
      do_abort(3'b101, 1'b1);

      for (int i = 0; i < 40; i++) begin
         a = rand_vec();
         mode = $urandom_range(0, 3);
         b = a;
         bitpos = $urandom_range(0, 68);
         b[bitpos] = ~b[bitpos];
         do_txn((mode == 1) ? b : a, (mode == 2) ? b : a, (mode == 3) ? b : a, 0,
                $urandom_range(0, 3), $urandom);
      end
      for (int i = 0; i < 300; i++) begin
         a = rand_vec();
         mode = $urandom_range(1, 3);
         b = a;
         bitpos = $urandom_range(0, 68);
         b[bitpos] = ~b[bitpos];
         do_txn((mode == 1) ? b : a, (mode == 2) ? b : a, (mode == 3) ? b : a, 0,
                $urandom_range(0, 1), $urandom);
      end
      check("cnt_saturated", cnt, 8'hFF);
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      exp_faulty = '0;
      exp_cnt = 0;
      @(negedge clk);
      check("clear_cnt", cnt, '0);
      check("clear_faulty", faulty, 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
